// File: rtl/router_pkg.sv
// Shared types and constants for the router transmit path: header field widths,
// the illegal destination code and the packet-source FSM state type.
package router_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam logic [LEN_W-1:0]  MAX_PAY_LEN  = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } tx_state_t;

  // Header byte layout seen by the router: length in the upper bits, port in the lower.
  function automatic logic [BYTE_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                     input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic cmd_legal(input logic [LEN_W-1:0]  len,
                                     input logic [ADDR_W-1:0] addr);
    return (addr != ADDR_INVALID) && (len != '0);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Signal bundle between the host/router and router_pkt_tx.
// The err_inject input exists only when ROUTER_TX_PARITY_INJ_EN is defined.
interface router_pkt_tx_if #(
  parameter int CW = 7
);
  import router_pkg::*;

  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;

  logic              start;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  pay_len;
  logic              start_ack;
  logic              cmd_err;

  logic              busy;
  logic              pkt_valid;
  logic [BYTE_W-1:0] data_out;
  logic              tx_active;
  logic              pkt_done;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic              err_inject;
`endif

  modport slave (
    input  wr_en, wr_data, start, dest_addr, pay_len, busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  err_inject,
`endif
    output fifo_full, fifo_count, start_ack, cmd_err, pkt_valid, data_out,
           tx_active, pkt_done
  );

  modport master (
    output wr_en, wr_data, start, dest_addr, pay_len, busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
    output err_inject,
`endif
    input  fifo_full, fifo_count, start_ack, cmd_err, pkt_valid, data_out,
           tx_active, pkt_done
  );

endinterface

// File: rtl/router_tx_fifo.sv
// Payload byte buffer: synchronous FIFO with show-ahead read data, so the head
// byte is visible on o_rd_data before it is popped.
module router_tx_fifo
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int CW         = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_rd_data,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: the storage array has no reset; flushing is done by clearing the
  // pointers and count, which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: frames buffered payload as header, payload and parity bytes,
// honouring busy back-pressure. Define ROUTER_TX_PARITY_INJ_EN to add err_inject.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  router_pkt_tx_if.slave  bus
);

  tx_state_t         r_state,     w_state_nxt;
  logic [BYTE_W-1:0] r_data_out,  w_data_out_nxt;
  logic              r_pkt_valid, w_pkt_valid_nxt;
  logic              r_start_ack, w_start_ack_nxt;
  logic              r_cmd_err,   w_cmd_err_nxt;
  logic              r_pkt_done,  w_pkt_done_nxt;
  logic              r_tx_active, w_tx_active_nxt;
  logic [BYTE_W-1:0] r_parity,    w_parity_nxt;
  logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_inj,       w_inj_nxt;

  logic              w_inj_in;
  logic              w_consume;
  logic              w_pop;
  logic [BYTE_W-1:0] w_rd_data;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

`ifdef ROUTER_TX_PARITY_INJ_EN
  assign w_inj_in = bus.err_inject;
`else
  assign w_inj_in = 1'b0;
`endif

  assign w_consume = !bus.busy;

  router_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (bus.wr_en),
    .i_wr_data (bus.wr_data),
    .i_pop     (w_pop && !w_empty),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_data_out_nxt  = r_data_out;
    w_pkt_valid_nxt = r_pkt_valid;
    w_start_ack_nxt = 1'b0;
    w_cmd_err_nxt   = 1'b0;
    w_pkt_done_nxt  = 1'b0;
    w_tx_active_nxt = r_tx_active;
    w_parity_nxt    = r_parity;
    w_remaining_nxt = r_remaining;
    w_inj_nxt       = r_inj;
    w_pop           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (!cmd_legal(bus.pay_len, bus.dest_addr)) begin
            w_cmd_err_nxt = 1'b1;
          end else if (w_count >= CW'(bus.pay_len)) begin
            // Whole payload already buffered, so pkt_valid never bubbles.
            w_start_ack_nxt = 1'b1;
            w_tx_active_nxt = 1'b1;
            w_data_out_nxt  = make_header(bus.pay_len, bus.dest_addr);
            w_pkt_valid_nxt = 1'b1;
            w_remaining_nxt = bus.pay_len;
            w_inj_nxt       = w_inj_in;
            w_state_nxt     = S_HEADER;
          end
        end
      end

      S_HEADER: begin
        if (w_consume) begin
          w_parity_nxt   = r_data_out;
          w_data_out_nxt = w_rd_data;
          w_pop          = 1'b1;
          w_state_nxt    = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (w_consume) begin
          w_parity_nxt    = r_parity ^ r_data_out;
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_data_out_nxt  = r_parity ^ r_data_out ^ {{(BYTE_W-1){1'b0}}, r_inj};
            w_pkt_valid_nxt = 1'b0;
            w_state_nxt     = S_PARITY;
          end else begin
            w_data_out_nxt = w_rd_data;
            w_pop          = 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (w_consume) begin
          w_pkt_done_nxt  = 1'b1;
          w_tx_active_nxt = 1'b0;
          w_data_out_nxt  = '0;
          w_state_nxt     = S_GAP;
        end
      end

      S_GAP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_data_out  <= '0;
      r_pkt_valid <= 1'b0;
      r_start_ack <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_tx_active <= 1'b0;
      r_parity    <= '0;
      r_remaining <= '0;
      r_inj       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data_out  <= w_data_out_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_start_ack <= w_start_ack_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_parity    <= w_parity_nxt;
      r_remaining <= w_remaining_nxt;
      r_inj       <= w_inj_nxt;
    end
  end

  assign bus.fifo_full  = w_full;
  assign bus.fifo_count = w_count;
  assign bus.start_ack  = r_start_ack;
  assign bus.cmd_err    = r_cmd_err;
  assign bus.pkt_valid  = r_pkt_valid;
  assign bus.data_out   = r_data_out;
  assign bus.tx_active  = r_tx_active;
  assign bus.pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: command table, directed corner cases and
// randomized packets checked against a queue-based packet model.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int FIFO_DEPTH = 64;
  localparam int CW         = 7;

  logic clk = 1'b0;
  logic resetn;

  router_pkt_tx_if #(.CW(CW)) bus();

  router_pkt_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];  // bytes the buffer should hold, oldest first
  logic [7:0] obs_q[$];    // bytes consumed by the router in the last packet

  typedef struct {
    int         nbuf;
    logic [1:0] dest;
    logic [5:0] len;
    bit         exp_ack;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_pkt_valid"},  32'(bus.pkt_valid),  32'd0);
    check({tag, "_data_out"},   32'(bus.data_out),   32'd0);
    check({tag, "_start_ack"},  32'(bus.start_ack),  32'd0);
    check({tag, "_cmd_err"},    32'(bus.cmd_err),    32'd0);
    check({tag, "_pkt_done"},   32'(bus.pkt_done),   32'd0);
    check({tag, "_tx_active"},  32'(bus.tx_active),  32'd0);
    check({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
    check({tag, "_fifo_full"},  32'(bus.fifo_full),  32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    check_zero_state("reset");
    resetn = 1'b1;
    model_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
  endtask

  task automatic issue_reject(input logic [1:0] dest, input logic [5:0] len, input bit exp_err);
    int cnt0;
    cnt0 = model_q.size();
    bus.start     = 1'b1;
    bus.dest_addr = dest;
    bus.pay_len   = len;
    tick();
    bus.start = 1'b0;
    check("rej_ack",       32'(bus.start_ack), 32'd0);
    check("rej_err",       32'(bus.cmd_err),   32'(exp_err));
    check("rej_valid",     32'(bus.pkt_valid), 32'd0);
    check("rej_active",    32'(bus.tx_active), 32'd0);
    tick();
    check("rej_err_pulse", 32'(bus.cmd_err),    32'd0);
    check("rej_count",     32'(bus.fifo_count), 32'(cnt0));
  endtask

  // Sends one accepted packet; the expected byte stream comes from the model queue.
  task automatic run_packet(input logic [1:0] dest, input logic [5:0] len, input logic inj,
                            input int stall_idx, input int stall_len, input bit rnd_busy,
                            output int cycles);
    logic [7:0] exp_b[$];
    logic [7:0] par;
    logic [7:0] b;
    logic [7:0] prev_d;
    logic       prev_v;
    logic       busy_now;
    logic       prev_busy;
    int         idx;
    int         stalled;
    int         nbusy;
    bit         done;

    par = {len, dest};
    exp_b.push_back(par);
    for (int i = 0; i < int'(len); i++) begin
      b = model_q.pop_front();
      exp_b.push_back(b);
      par = par ^ b;
    end
    exp_b.push_back(par ^ {7'd0, inj});
    obs_q.delete();

    bus.start     = 1'b1;
    bus.dest_addr = dest;
    bus.pay_len   = len;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.err_inject = inj;
`endif
    tick();
    bus.start     = 1'b0;
    bus.dest_addr = 2'($urandom);
    bus.pay_len   = 6'($urandom);
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.err_inject = ~inj;
`endif
    check("ack",     32'(bus.start_ack), 32'd1);
    check("ack_err", 32'(bus.cmd_err),   32'd0);

    cycles = 0; idx = 0; stalled = 0; nbusy = 0;
    prev_busy = 1'b0; prev_d = 8'd0; prev_v = 1'b0; done = 1'b0;
    while (!done) begin
      if (bus.pkt_done) begin
        done = 1'b1;
      end else if (cycles >= 400) begin
        errors++;
        checks++;
        $display("FAIL pkt_timeout: no pkt_done after %0d cycles, expected within 400", cycles);
        done = 1'b1;
      end else begin
        if (cycles == 1) check("ack_pulse", 32'(bus.start_ack), 32'd0);
        check("tx_active", 32'(bus.tx_active), 32'd1);
        if (prev_busy) begin
          check("hold_data",  32'(bus.data_out),  32'(prev_d));
          check("hold_valid", 32'(bus.pkt_valid), 32'(prev_v));
        end
        if (idx == stall_idx && stalled < stall_len) begin
          busy_now = 1'b1;
          stalled++;
        end else begin
          busy_now = rnd_busy ? ($urandom_range(3) == 0) : 1'b0;
        end
        if (busy_now) begin
          nbusy++;
        end else begin
          if (idx < exp_b.size()) begin
            check("byte",  32'(bus.data_out),  32'(exp_b[idx]));
            check("valid", 32'(bus.pkt_valid), 32'(idx <= int'(len)));
            obs_q.push_back(bus.data_out);
          end else begin
            errors++;
            checks++;
            $display("FAIL extra_byte: got byte %0d (0x%0h), expected only %0d bytes",
                     idx, bus.data_out, exp_b.size());
          end
          idx++;
        end
        prev_busy = busy_now;
        prev_d    = bus.data_out;
        prev_v    = bus.pkt_valid;
        bus.busy  = busy_now;
        tick();
        cycles++;
      end
    end
    bus.busy = 1'b0;

    check("byte_count",  32'(idx),            32'(int'(len) + 2));
    check("pkt_cycles",  32'(cycles),         32'(int'(len) + 2 + nbusy));
    check("gap_data",    32'(bus.data_out),   32'd0);
    check("gap_valid",   32'(bus.pkt_valid),  32'd0);
    check("done_active", 32'(bus.tx_active),  32'd0);

    // A legal start during the gap cycle must be ignored.
    bus.start     = 1'b1;
    bus.dest_addr = 2'd0;
    bus.pay_len   = 6'd1;
    tick();
    bus.start = 1'b0;
    check("gap_start_ignored", 32'(bus.start_ack),  32'd0);
    check("done_pulse",        32'(bus.pkt_done),   32'd0);
    check("post_count",        32'(bus.fifo_count), 32'(model_q.size()));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         cyc;
    int         n;
    bit         seen;
    logic [1:0] dest;
    logic [5:0] len;
    logic       inj;

    bus.wr_en = 1'b0; bus.wr_data = 8'd0; bus.start = 1'b0;
    bus.dest_addr = 2'd0; bus.pay_len = 6'd0; bus.busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    bus.err_inject = 1'b0;
`endif
    resetn = 1'b0;

    // nbuf, dest, len, expect ack, expect cmd_err
    vecs[0] = '{3,  2'd1, 6'd3, 1'b1, 1'b0};
    vecs[1] = '{5,  2'd3, 6'd5, 1'b0, 1'b1};
    vecs[2] = '{5,  2'd0, 6'd0, 1'b0, 1'b1};
    vecs[3] = '{2,  2'd0, 6'd4, 1'b0, 1'b0};
    vecs[4] = '{4,  2'd2, 6'd4, 1'b1, 1'b0};
    vecs[5] = '{0,  2'd3, 6'd0, 1'b0, 1'b1};
    vecs[6] = '{10, 2'd2, 6'd1, 1'b1, 1'b0};
    vecs[7] = '{1,  2'd0, 6'd2, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nbuf; k++) push_byte(8'($urandom));
      if (vecs[v].exp_ack) run_packet(vecs[v].dest, vecs[v].len, 1'b0, -1, 0, 1'b0, cyc);
      else                 issue_reject(vecs[v].dest, vecs[v].len, vecs[v].exp_err);
    end

    // Basic packet with known bytes.
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_packet(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, cyc);
    check("basic_nbytes", 32'(obs_q.size()), 32'd5);
    check("basic_header", 32'(obs_q[0]), 32'h0D);
    check("basic_parity", 32'(obs_q[4]), 32'h0D);
    check("basic_cycles", 32'(cyc), 32'd5);

    // Back-pressure: stall three cycles on byte 0x22.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_packet(2'd1, 6'd3, 1'b0, 2, 3, 1'b0, cyc);
    check("bp_cycles", 32'(cyc), 32'd8);
    check("bp_byte2",  32'(obs_q[2]), 32'h22);
    check("bp_parity", 32'(obs_q[4]), 32'h0D);

    // Insufficient data, then re-assert after topping up.
    do_reset();
    push_byte(8'h01); push_byte(8'h02);
    issue_reject(2'd0, 6'd4, 1'b0);
    push_byte(8'h03); push_byte(8'h04);
    run_packet(2'd0, 6'd4, 1'b0, -1, 0, 1'b0, cyc);
    check("insuf_nbytes", 32'(obs_q.size()), 32'd6);

    // Full buffer, dropped write, maximum length, then pointer wrap.
    do_reset();
    for (int k = 0; k < 64; k++) push_byte(8'($urandom));
    check("full_flag",  32'(bus.fifo_full),  32'd1);
    check("full_count", 32'(bus.fifo_count), 32'd64);
    push_byte(8'hAA);
    check("drop_count", 32'(bus.fifo_count), 32'd64);
    run_packet(2'd0, 6'd63, 1'b0, -1, 0, 1'b1, cyc);
    check("max_header", 32'(obs_q[0]), 32'hFC);
    check("max_left",   32'(bus.fifo_count), 32'd1);
    for (int k = 0; k < 10; k++) push_byte(8'($urandom));
    run_packet(2'd2, 6'd11, 1'b0, -1, 0, 1'b0, cyc);

    // Reset after two payload bytes aborts with no parity byte.
    do_reset();
    for (int k = 1; k <= 5; k++) push_byte(8'(k));
    bus.start = 1'b1; bus.dest_addr = 2'd2; bus.pay_len = 6'd5;
    tick();
    bus.start = 1'b0;
    check("mid_ack", 32'(bus.start_ack), 32'd1);
    tick(); tick(); tick();
    check("mid_valid", 32'(bus.pkt_valid), 32'd1);
    check("mid_byte3", 32'(bus.data_out),  32'd3);
    resetn = 1'b0;
    tick();
    check_zero_state("mid_reset");
    resetn = 1'b1;
    model_q.delete();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.tx_active || bus.pkt_valid || bus.pkt_done || (bus.data_out != 8'd0)) seen = 1'b1;
    end
    check("no_parity_after_reset", 32'(seen), 32'd0);

`ifdef ROUTER_TX_PARITY_INJ_EN
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    run_packet(2'd1, 6'd3, 1'b1, -1, 0, 1'b0, cyc);
    check("inj_parity", 32'(obs_q[4]), 32'h0C);
`endif

    // Randomized packets, busy and illegal commands against the model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 24);
      for (int k = 0; k < n; k++) push_byte(8'($urandom));
      len  = 6'($urandom_range(1, 63));
      dest = 2'($urandom_range(0, 2));
      inj  = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
      inj = 1'($urandom_range(1));
`endif
      if ($urandom_range(9) == 0)             issue_reject(2'd3, len, 1'b1);
      else if (int'(len) <= model_q.size())   run_packet(dest, len, inj, -1, 0, 1'b1, cyc);
      else                                    issue_reject(dest, len, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the router input port. It buffers payload bytes from a host and sends one framed packet per command. Each packet is a header byte, 1-63 payload bytes, and a trailing parity byte, and the block honours the router's busy back-pressure. It is the transmit-side counterpart of the router's input register/parity-check path, and it lives in the testbench-synthesizable source and loopback path.

Parameters:
FIFO_DEPTH, 64, payload buffer depth in bytes (power of two, at least 64)
CW, 7, width of the buffer occupancy count, equal to log2(FIFO_DEPTH)+1

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  synchronous, active-low reset
wr_en  in  1  host pushes wr_data into the payload buffer
wr_data  in  8  payload byte
fifo_full  out  1  buffer full; a write while full is dropped
fifo_count  out  CW  bytes currently buffered
start  in  1  send-packet command
dest_addr  in  2  destination port 0-2; 3 is illegal
pay_len  in  6  payload length 1-63; 0 is illegal
start_ack  out  1  one-cycle pulse when a command is accepted
cmd_err  out  1  one-cycle pulse when a command is rejected
busy  in  1  router back-pressure; the current byte is held while high
pkt_valid  out  1  high during header and payload bytes
data_out  out  8  byte to the router
tx_active  out  1  high from command acceptance until pkt_done
pkt_done  out  1  one-cycle pulse after the parity byte is consumed

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is synchronous and active-low.
- Reset values: pkt_valid=0, data_out=0, start_ack=0, cmd_err=0, pkt_done=0, tx_active=0, fifo_count=0, FSM in IDLE, buffer flushed.
- Reset mid-packet: aborts the packet immediately, with no parity byte sent.
- Byte consumption: a byte on data_out is consumed at a rising edge where busy=0. While busy=1, data_out and pkt_valid hold unchanged.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE, command handling when start=1:
  - dest_addr=3 or pay_len=0: cmd_err pulses next cycle; stay IDLE.
  - Otherwise, if fifo_count >= pay_len: latch the command; start_ack pulses next cycle; go to HEADER.
  - Otherwise (not enough payload buffered): the command is ignored with no pulse. The host must re-assert start.
- HEADER: header = {pay_len, dest_addr}. It is driven with pkt_valid=1 in the cycle after acceptance. On consumption the int parity register is loaded with the header, the first buffer byte is popped, and the FSM goes to PAYLOAD.
- PAYLOAD:
  - Drives the popped byte with pkt_valid=1.
  - Each consumption XORs the byte into parity, decrements a 6-bit remaining counter, and pops the next byte.
  - When the last byte is consumed, go to PARITY.
  - pkt_valid is contiguous from header to last payload byte, with no bubbles; pre-buffering guarantees this.
- PARITY: drives the parity byte (XOR of header and all payload bytes) with pkt_valid=0. On consumption, pkt_done pulses and the FSM goes to GAP.
- GAP: one cycle with pkt_valid=0 and data_out=0, then IDLE. A start in GAP is ignored.
- Buffer writes:
  - Writes are accepted in every state; a simultaneous push and pop leaves the count unchanged.
  - A write while fifo_full=1 is dropped and the count does not change.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Header dest_addr is fixed per packet; inputs changing mid-packet have no effect.

Optional Feature:
ROUTER_TX_PARITY_INJ_EN
- Defined: adds input port `err_inject` (1 bit), sampled at command acceptance. If it was 1, the transmitted parity byte has bit 0 inverted, producing a deliberate router parity error.
- Undefined: the port is absent and parity is always correct.

Decomposition:
- Shared package router_pkg:
  - FSM state enum tx_state_t.
  - Constant ADDR_INVALID=2'b11.
  - Constant MAX_PAY_LEN=63.
  - Header field widths: ADDR_W=2, LEN_W=6.
  - Byte width 8.
- Sub-module router_tx_fifo: synchronous FIFO, 8-bit wide, depth FIFO_DEPTH, with count, full and empty outputs. It keeps the FSM and parity logic separate from storage.

Test Plan:
- Basic packet: write 3 bytes 0x11,0x22,0x33; start with dest=1, len=3, busy=0. Required output: header 0x0D, then 0x11, 0x22, 0x33 with pkt_valid=1, then parity 0x0D^0x11^0x22^0x33=0x0D with pkt_valid=0, then pkt_done.
- Back-pressure: same packet with busy=1 for 3 cycles during byte 0x22. data_out holds 0x22 with pkt_valid=1 for all busy cycles; the byte sequence is unchanged and total packet time is +3 cycles.
- Illegal commands: start with dest=3, len=5, then dest=0, len=0. Each gives a cmd_err pulse, no start_ack, pkt_valid stays 0, and fifo_count is unchanged.
- Insufficient data: 2 bytes buffered, start with len=4, so no ack. Write 2 more bytes and re-assert start: accepted and 4 bytes sent.
- Max length and buffer full: write 64 bytes, so fifo_full=1 and a 65th write is dropped. Send a len=63 packet: header 0xFC, correct parity, and fifo_count=1 afterwards.
- Reset mid-payload: drive resetn=0 for 1 cycle after 2 payload bytes. All outputs are 0 and fifo_count=0 on the next cycle; no parity byte is ever sent.
- With ROUTER_TX_PARITY_INJ_EN: the basic packet sent with err_inject=1 carries parity 0x0C.
